// File: rtl/ram_sp_be_acc_ctrl.sv
// Initiator for a single-port bit-enable SRAM: round-robin write/read arbitration,
// address range checking and a credit-limited, order-preserving read-return buffer.
module ram_sp_be_acc_ctrl #(
    parameter int ADR_WD  = 8,
    parameter int DAT_WD  = 128,
    parameter int DEPTH   = 192,
    parameter int RTN_DEP = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_req_i,
    input  logic [ADR_WD-1:0] wr_adr_i,
    input  logic [DAT_WD-1:0] wr_msk_i,
    input  logic [DAT_WD-1:0] wr_dat_i,
    output logic              wr_ack_o,
    input  logic              rd_req_i,
    input  logic [ADR_WD-1:0] rd_adr_i,
    output logic              rd_ack_o,
    output logic              rd_val_o,
    output logic [DAT_WD-1:0] rd_dat_o,
    output logic              rd_err_o,
    input  logic              rd_rdy_i,
    output logic              wr_err_o,
    output logic [ADR_WD-1:0] mem_adr_o,
    output logic [DAT_WD-1:0] mem_wen_o,
    output logic [DAT_WD-1:0] mem_wdat_o,
    output logic              mem_ren_o,
    input  logic [DAT_WD-1:0] mem_rdat_i
);
    localparam int PTR_WD = (RTN_DEP > 1) ? $clog2(RTN_DEP) : 1;
    localparam int CNT_WD = PTR_WD + 1;

    typedef enum logic {PRI_WR = 1'b0, PRI_RD = 1'b1} pri_e;

    pri_e              r_pri;
    pri_e              w_pri_nxt;
    logic [DAT_WD:0]   r_buf [RTN_DEP];
    logic [PTR_WD-1:0] r_wptr;
    logic [PTR_WD-1:0] r_rptr;
    logic [CNT_WD-1:0] r_cnt;
    logic              r_infl;
    logic              r_infl_err;
    logic [ADR_WD-1:0] r_adr;

    logic              w_wr_oor;
    logic              w_rd_oor;
    logic [CNT_WD-1:0] w_occ;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_wr_gnt;
    logic              w_rd_gnt;
    logic              w_wr_do;
    logic              w_rd_do;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DAT_WD-1:0] w_ret_dat;
    logic [DAT_WD:0]   w_head;

    assign w_wr_oor = {1'b0, wr_adr_i} >= (ADR_WD+1)'(DEPTH);
    assign w_rd_oor = {1'b0, rd_adr_i} >= (ADR_WD+1)'(DEPTH);

    // Credit counts the read in flight so a push can never find the buffer full.
    assign w_occ   = r_cnt + CNT_WD'(r_infl);
    assign w_wr_ok = rstn && wr_req_i;
    assign w_rd_ok = rstn && rd_req_i && (w_occ < CNT_WD'(RTN_DEP));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_pri <= PRI_WR;
        else       r_pri <= w_pri_nxt;
    end

    always_comb begin
        w_pri_nxt = r_pri;
        w_wr_gnt  = 1'b0;
        w_rd_gnt  = 1'b0;
        if (w_wr_ok && w_rd_ok) begin
            if (r_pri == PRI_WR) w_wr_gnt = 1'b1;
            else                 w_rd_gnt = 1'b1;
            w_pri_nxt = (r_pri == PRI_WR) ? PRI_RD : PRI_WR;
        end else begin
            w_wr_gnt = w_wr_ok;
            w_rd_gnt = w_rd_ok;
        end
    end

    assign w_wr_do = w_wr_gnt && !w_wr_oor;
    assign w_rd_do = w_rd_gnt && !w_rd_oor;

    assign wr_ack_o   = w_wr_gnt;
    assign rd_ack_o   = w_rd_gnt;
    assign wr_err_o   = w_wr_gnt && w_wr_oor;
    assign mem_wen_o  = w_wr_do ? wr_msk_i : '0;
    assign mem_wdat_o = w_wr_do ? wr_dat_i : '0;
    assign mem_ren_o  = w_rd_do;
    assign mem_adr_o  = w_wr_do ? wr_adr_i : (w_rd_do ? rd_adr_i : r_adr);

    // Return path: the word arriving from the SRAM bypasses an empty buffer.
    assign w_ret_dat = r_infl_err ? '0 : mem_rdat_i;
    assign w_empty   = (r_cnt == '0);
    assign w_head    = w_empty ? (r_infl ? {r_infl_err, w_ret_dat} : '0) : r_buf[r_rptr];
    assign rd_val_o  = !w_empty || r_infl;
    assign rd_err_o  = w_head[DAT_WD];
    assign rd_dat_o  = w_head[DAT_WD-1:0];
    assign w_pop     = rd_val_o && rd_rdy_i;
    assign w_push    = r_infl && !(w_empty && rd_rdy_i);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_infl     <= 1'b0;
            r_infl_err <= 1'b0;
            r_adr      <= '0;
        end else begin
            r_infl     <= w_rd_gnt;
            r_infl_err <= w_rd_gnt && w_rd_oor;
            r_adr      <= mem_adr_o;
            r_cnt      <= r_cnt + CNT_WD'(w_push) - CNT_WD'(w_pop && !w_empty);
            if (w_push)             r_wptr <= r_wptr + PTR_WD'(1);
            if (w_pop && !w_empty)  r_rptr <= r_rptr + PTR_WD'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_wptr] <= {r_infl_err, w_ret_dat};
    end
endmodule

// File: tb/tb_ram_sp_be_acc_ctrl.sv
// Bench for ram_sp_be_acc_ctrl: SRAM stub, transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ram_sp_be_acc_ctrl;
    localparam int ADR_WD  = 8;
    localparam int DAT_WD  = 128;
    localparam int DEPTH   = 192;
    localparam int RTN_DEP = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              wr_req_i = 1'b0;
    logic [ADR_WD-1:0] wr_adr_i = '0;
    logic [DAT_WD-1:0] wr_msk_i = '0;
    logic [DAT_WD-1:0] wr_dat_i = '0;
    logic              wr_ack_o;
    logic              rd_req_i = 1'b0;
    logic [ADR_WD-1:0] rd_adr_i = '0;
    logic              rd_ack_o;
    logic              rd_val_o;
    logic [DAT_WD-1:0] rd_dat_o;
    logic              rd_err_o;
    logic              rd_rdy_i = 1'b0;
    logic              wr_err_o;
    logic [ADR_WD-1:0] mem_adr_o;
    logic [DAT_WD-1:0] mem_wen_o;
    logic [DAT_WD-1:0] mem_wdat_o;
    logic              mem_ren_o;
    logic [DAT_WD-1:0] mem_rdat_i = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_sp_be_acc_ctrl #(.ADR_WD(ADR_WD), .DAT_WD(DAT_WD), .DEPTH(DEPTH), .RTN_DEP(RTN_DEP)) dut (
        .clk(clk), .rstn(rstn),
        .wr_req_i(wr_req_i), .wr_adr_i(wr_adr_i), .wr_msk_i(wr_msk_i), .wr_dat_i(wr_dat_i),
        .wr_ack_o(wr_ack_o), .rd_req_i(rd_req_i), .rd_adr_i(rd_adr_i), .rd_ack_o(rd_ack_o),
        .rd_val_o(rd_val_o), .rd_dat_o(rd_dat_o), .rd_err_o(rd_err_o), .rd_rdy_i(rd_rdy_i),
        .wr_err_o(wr_err_o), .mem_adr_o(mem_adr_o), .mem_wen_o(mem_wen_o),
        .mem_wdat_o(mem_wdat_o), .mem_ren_o(mem_ren_o), .mem_rdat_i(mem_rdat_i)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [DAT_WD:0] act, input logic [DAT_WD:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // SRAM stub: inputs captured mid-cycle, applied at the edge.
    logic [DAT_WD-1:0] sram [256];
    logic [DAT_WD-1:0] s_wen, s_wdat;
    logic [ADR_WD-1:0] s_adr;
    logic              s_ren;
    initial begin
        foreach (sram[i]) sram[i] = '0;
        s_wen = '0; s_wdat = '0; s_adr = '0; s_ren = 1'b0;
    end
    always @(negedge clk) begin
        s_wen = mem_wen_o; s_wdat = mem_wdat_o; s_adr = mem_adr_o; s_ren = mem_ren_o;
    end
    always @(posedge clk) begin
        if (s_ren) mem_rdat_i <= sram[s_adr];
        if (|s_wen) sram[s_adr] <= (sram[s_adr] & ~s_wen) | (s_wdat & s_wen);
    end

    // Reference model: a queue of accepted-but-unconsumed reads, each carrying the word
    // the memory held when it was granted and the cycle it was granted in.
    typedef struct { logic err; logic [DAT_WD-1:0] dat; int tag; } ret_t;
    ret_t              rq[$];
    logic [DAT_WD:0]   pop_q[$];
    logic [DAT_WD-1:0] refmem [256];
    string             glog = "";
    bit                m_pri_rd = 1'b0;
    logic [ADR_WD-1:0] m_last_adr = '0;
    int                cyc = 0;
    logic              m_el_rd, m_g_wr, m_g_rd, m_wr_oor, m_rd_oor, m_val;
    logic [DAT_WD-1:0] m_wen, m_wdat;
    logic [ADR_WD-1:0] m_adr;
    ret_t              m_ent;
    initial foreach (refmem[i]) refmem[i] = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            chk1("rst_outs", |{wr_ack_o, rd_ack_o, rd_val_o, rd_dat_o, rd_err_o, wr_err_o,
                               mem_adr_o, mem_wen_o, mem_wdat_o, mem_ren_o}, 1'b0);
            rq.delete();
            m_pri_rd   = 1'b0;
            m_last_adr = '0;
        end else begin
            m_el_rd  = rd_req_i && (rq.size() < RTN_DEP);
            m_g_wr   = wr_req_i && (!m_el_rd || !m_pri_rd);
            m_g_rd   = m_el_rd && (!wr_req_i || m_pri_rd);
            if (wr_req_i && m_el_rd) m_pri_rd = !m_pri_rd;
            m_wr_oor = int'(wr_adr_i) >= DEPTH;
            m_rd_oor = int'(rd_adr_i) >= DEPTH;
            m_val    = (rq.size() > 0) && (rq[0].tag < cyc);
            m_wen    = (m_g_wr && !m_wr_oor) ? wr_msk_i : '0;
            m_wdat   = (m_g_wr && !m_wr_oor) ? wr_dat_i : '0;
            if (m_g_wr && !m_wr_oor)      m_adr = wr_adr_i;
            else if (m_g_rd && !m_rd_oor) m_adr = rd_adr_i;
            else                          m_adr = m_last_adr;
            m_last_adr = m_adr;

            chk1("wr_ack", wr_ack_o, m_g_wr);
            chk1("rd_ack", rd_ack_o, m_g_rd);
            chk1("wr_err", wr_err_o, m_g_wr && m_wr_oor);
            chkw("mem_wen", {1'b0, mem_wen_o}, {1'b0, m_wen});
            chkw("mem_wdat", {1'b0, mem_wdat_o}, {1'b0, m_wdat});
            chk1("mem_ren", mem_ren_o, m_g_rd && !m_rd_oor);
            chki("mem_adr", int'(mem_adr_o), int'(m_adr));
            chk1("one_op", (|mem_wen_o) && mem_ren_o, 1'b0);
            chk1("rd_val", rd_val_o, m_val);
            if (m_val) begin
                chkw("rd_data", {rd_err_o, rd_dat_o}, {rq[0].err, rq[0].dat});
                if (rd_rdy_i) begin
                    pop_q.push_back({rd_err_o, rd_dat_o});
                    void'(rq.pop_front());
                end
            end
            if (m_g_wr) begin
                glog = {glog, "W"};
                if (!m_wr_oor)
                    refmem[wr_adr_i] = (refmem[wr_adr_i] & ~wr_msk_i) | (wr_dat_i & wr_msk_i);
            end
            if (m_g_rd) begin
                glog = {glog, "R"};
                m_ent.err = m_rd_oor;
                m_ent.dat = m_rd_oor ? '0 : refmem[rd_adr_i];
                m_ent.tag = cyc;
                rq.push_back(m_ent);
            end
        end
    end

    task automatic wr_txn(input logic [ADR_WD-1:0] a, input logic [DAT_WD-1:0] m,
                          input logic [DAT_WD-1:0] d, output logic err, output logic [DAT_WD-1:0] wen);
        bit got = 1'b0;
        err = 1'b0; wen = '0;
        wr_adr_i = a; wr_msk_i = m; wr_dat_i = d; wr_req_i = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (wr_ack_o) begin got = 1'b1; err = wr_err_o; wen = mem_wen_o; end
            @(posedge clk); #1;
        end
        wr_req_i = 1'b0;
        chk1("wr_handshake", got, 1'b1);
    endtask

    task automatic rd_txn(input logic [ADR_WD-1:0] a);
        bit got = 1'b0;
        rd_adr_i = a; rd_req_i = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (rd_ack_o) got = 1'b1;
            @(posedge clk); #1;
        end
        rd_req_i = 1'b0;
        chk1("rd_handshake", got, 1'b1);
    endtask

    logic              e;
    logic [DAT_WD-1:0] w;
    int                acks, seen;
    logic              a_now;

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        rd_rdy_i = 1'b1;

        // 1: full write then read back, data one cycle after ack
        wr_txn(8'd5, '1, {16{8'hA5}}, e, w);
        chkw("t1_wen", {1'b0, w}, {1'b0, {DAT_WD{1'b1}}});
        rd_txn(8'd5);
        @(negedge clk);
        chk1("t1_val", rd_val_o, 1'b1);
        chkw("t1_dat", {rd_err_o, rd_dat_o}, {1'b0, {16{8'hA5}}});
        @(posedge clk); #1;

        // 2: partial mask clears only the low byte
        wr_txn(8'd7, '1, '1, e, w);
        wr_txn(8'd7, {{(DAT_WD-8){1'b0}}, 8'hFF}, '0, e, w);
        rd_txn(8'd7);
        @(negedge clk);
        chkw("t2_dat", {rd_err_o, rd_dat_o}, {1'b0, {(DAT_WD-8){1'b1}}, 8'h00});
        @(posedge clk); #1;

        // 3: both channels requesting for 6 cycles
        glog = "";
        wr_adr_i = 8'd10; wr_msk_i = '1; wr_dat_i = {8{16'h3C5A}}; wr_req_i = 1'b1;
        rd_adr_i = 8'd10; rd_req_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        wr_req_i = 1'b0; rd_req_i = 1'b0;
        checks++;
        if (glog != "WRWRWR") begin
            failures++;
            $display("FAIL t3_order: got %s expected WRWRWR", glog);
        end
        repeat (3) @(posedge clk);
        #1;

        // 4: consumer stalled, only RTN_DEP reads accepted, then in-order drain
        for (int i = 0; i < 4; i++) wr_txn(8'(20 + i), '1, {16{8'(32 + i)}}, e, w);
        pop_q.delete();
        rd_rdy_i = 1'b0;
        rd_adr_i = 8'd20; rd_req_i = 1'b1; acks = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a_now = rd_ack_o;
            if (a_now) acks++;
            @(posedge clk); #1;
            if (a_now) begin
                if (acks == 4) rd_req_i = 1'b0;
                else rd_adr_i = 8'(20 + acks);
            end
        end
        chki("t4_acked_stalled", acks, 2);
        @(negedge clk);
        chkw("t4_hold", {rd_err_o, rd_dat_o}, {1'b0, {16{8'h20}}});
        @(posedge clk); #1;
        rd_rdy_i = 1'b1;
        for (int c = 0; c < 20 && acks < 4; c++) begin
            @(negedge clk);
            a_now = rd_ack_o;
            if (a_now) acks++;
            @(posedge clk); #1;
            if (a_now) begin
                if (acks == 4) rd_req_i = 1'b0;
                else rd_adr_i = 8'(20 + acks);
            end
        end
        rd_req_i = 1'b0;
        chki("t4_acked_total", acks, 4);
        repeat (6) @(posedge clk);
        #1;
        chki("t4_count", pop_q.size(), 4);
        for (int i = 0; i < 4 && i < pop_q.size(); i++)
            chkw("t4_order", pop_q[i], {1'b0, {16{8'(32 + i)}}});

        // 5: out-of-range write and read
        wr_txn(8'd192, '1, '1, e, w);
        chk1("t5_wr_err", e, 1'b1);
        chkw("t5_wen", {1'b0, w}, '0);
        @(negedge clk);
        chk1("t5_pulse_end", wr_err_o, 1'b0);
        @(posedge clk); #1;
        rd_txn(8'd200);
        @(negedge clk);
        chk1("t5_val", rd_val_o, 1'b1);
        chkw("t5_dat", {rd_err_o, rd_dat_o}, {1'b1, {DAT_WD{1'b0}}});
        @(posedge clk); #1;
        rd_txn(8'd192);
        @(negedge clk);
        chkw("t5_unwritten", {rd_err_o, rd_dat_o}, {1'b1, {DAT_WD{1'b0}}});
        @(posedge clk); #1;

        // 6: reset with a full buffer and a read in flight
        rd_rdy_i = 1'b0;
        rd_txn(8'd20);
        rd_txn(8'd21);
        chk1("t6_val_before", rd_val_o, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk1("t6_async", |{wr_ack_o, rd_ack_o, rd_val_o, rd_dat_o, rd_err_o, wr_err_o,
                           mem_adr_o, mem_wen_o, mem_wdat_o, mem_ren_o}, 1'b0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        rd_rdy_i = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rd_val_o) seen++;
        end
        chki("t6_stale", seen, 0);
        @(posedge clk); #1;
        rd_txn(8'd21);
        @(negedge clk);
        chkw("t6_after", {rd_err_o, rd_dat_o}, {1'b0, {16{8'h21}}});
        @(posedge clk); #1;
        repeat (2) @(posedge clk);

        #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
